// File: rtl/lcd_sequencer.sv
// lcd_sequencer: feeds an HD44780-style single-transfer LCD controller
// one byte at a time; runs the init sequence, then rewrites a 2x16 frame.
module lcd_sequencer #(
    parameter int POWERON_WAIT = 750000,
    parameter int CMD_WAIT     = 2000,
    parameter int CLEAR_WAIT   = 82000,
    parameter int CNT_W        = 20
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [4:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       refresh,
    input  logic       lcd_done,
    output logic       lcd_start,
    output logic       lcd_rs,
    output logic [7:0] lcd_data,
    output logic       busy,
    output logic       init_done
);

    localparam logic [2:0] S_PWR     = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_WAITRDY = 3'd2;
    localparam logic [2:0] S_ACK     = 3'd3;
    localparam logic [2:0] S_XFER    = 3'd4;
    localparam logic [2:0] S_GAP     = 3'd5;
    localparam logic [2:0] S_IDLE    = 3'd6;

    localparam logic [CNT_W-1:0] PWR_LAST = CNT_W'(POWERON_WAIT - 1);
    localparam logic [CNT_W-1:0] CMD_LAST = CNT_W'(CMD_WAIT - 1);
    localparam logic [CNT_W-1:0] CLR_LAST = CNT_W'(CLEAR_WAIT - 1);

    localparam logic [5:0] STEP_CLEAR = 6'd2;
    localparam logic [5:0] STEP_LINE1 = 6'd4;
    localparam logic [5:0] STEP_LINE2 = 6'd22;
    localparam logic [5:0] STEP_LAST  = 6'd37;

    logic [2:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [5:0]       step_q, step_d;
    logic             pend_q, pend_d;
    logic             start_q, start_d;
    logic             rs_q, rs_d;
    logic [7:0]       data_q, data_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic [7:0]       fb_q [32];
    logic [7:0]       fb_d [32];

    logic [4:0]       fb_idx;
    logic             tbl_rs;
    logic [7:0]       tbl_data;
    logic [CNT_W-1:0] gap_last;

    // Host write port into the frame buffer.
    always_comb begin
        for (int i = 0; i < 32; i++) begin
            fb_d[i] = fb_q[i];
        end
        if (wr_en) begin
            fb_d[wr_addr] = wr_data;
        end
    end

    // Step table: fixed commands, line addresses, or buffered characters.
    always_comb begin
        tbl_rs   = 1'b1;
        tbl_data = 8'h00;
        if (step_q >= STEP_LINE2) begin
            fb_idx = 5'(step_q - 6'd6);
        end else begin
            fb_idx = 5'(step_q - 6'd5);
        end
        case (step_q)
            6'd0: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'h38;
            end
            6'd1: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'h0C;
            end
            6'd2: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'h01;
            end
            6'd3: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'h06;
            end
            6'd4: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'h80;
            end
            6'd21: begin
                tbl_rs   = 1'b0;
                tbl_data = 8'hC0;
            end
            default: begin
                tbl_data = fb_q[fb_idx];
            end
        endcase
    end

    // The clear command needs a much longer settle time than the rest.
    always_comb begin
        gap_last = (step_q == STEP_CLEAR) ? CLR_LAST : CMD_LAST;
    end

    // Sequencer FSM; the counter is zero on entry to every state.
    always_comb begin
        state_d = state_q;
        cnt_d   = '0;
        step_d  = step_q;
        pend_d  = pend_q;
        start_d = start_q;
        rs_d    = rs_q;
        data_d  = data_q;
        busy_d  = busy_q;
        done_d  = done_q;

        if (refresh && (state_q != S_IDLE)) begin
            pend_d = 1'b1;
        end

        unique case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    step_d  = 6'd0;
                    state_d = S_LOAD;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_LOAD: begin
                rs_d    = tbl_rs;
                data_d  = tbl_data;
                state_d = S_WAITRDY;
            end
            S_WAITRDY: begin
                if (lcd_done) begin
                    start_d = 1'b1;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                if (!lcd_done) begin
                    start_d = 1'b0;
                    state_d = S_XFER;
                end
            end
            S_XFER: begin
                if (lcd_done) begin
                    state_d = S_GAP;
                end
            end
            S_GAP: begin
                if (cnt_q == gap_last) begin
                    if (step_q == STEP_LAST) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = S_IDLE;
                    end else begin
                        step_d  = step_q + 1'b1;
                        state_d = S_LOAD;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (refresh || pend_q) begin
                    pend_d  = 1'b0;
                    step_d  = STEP_LINE1;
                    busy_d  = 1'b1;
                    state_d = S_LOAD;
                end
            end
            default: begin
                state_d = S_PWR;
            end
        endcase
    end

    // State registers; reset aborts any transfer and restarts power-up.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_PWR;
            cnt_q   <= '0;
            step_q  <= 6'd0;
            pend_q  <= 1'b0;
            start_q <= 1'b0;
            rs_q    <= 1'b0;
            data_q  <= 8'h00;
            busy_q  <= 1'b1;
            done_q  <= 1'b0;
            for (int i = 0; i < 32; i++) begin
                fb_q[i] <= 8'h20;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            step_q  <= step_d;
            pend_q  <= pend_d;
            start_q <= start_d;
            rs_q    <= rs_d;
            data_q  <= data_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            for (int i = 0; i < 32; i++) begin
                fb_q[i] <= fb_d[i];
            end
        end
    end

    assign lcd_start = start_q;
    assign lcd_rs    = rs_q;
    assign lcd_data  = data_q;
    assign busy      = busy_q;
    assign init_done = done_q;

endmodule

// File: tb/tb_lcd_sequencer.sv
// tb_lcd_sequencer: directed bench with a behavioural LCD controller
// (enable pulse of CLK_WAIT cycles) and an LCD_EN byte monitor.
module tb_lcd_sequencer;

    localparam int CLK_WAIT = 3;
    localparam int BUDGET   = 5000;

    logic       clk = 1'b0;
    logic       reset;
    logic       wr_en;
    logic [4:0] wr_addr;
    logic [7:0] wr_data;
    logic       refresh;
    logic       lcd_done;
    logic       lcd_start;
    logic       lcd_rs;
    logic [7:0] lcd_data;
    logic       busy;
    logic       init_done;
    logic       lcd_en;

    int n_cmp = 0;
    int n_bad = 0;

    logic [8:0] mon_q [$];
    logic [7:0] shadow [32];

    typedef struct {
        logic       wr;
        logic [4:0] addr;
        logic [7:0] data;
        int         idx;
        logic [8:0] exp;
    } vec_t;

    vec_t vt [6];

    lcd_sequencer #(
        .POWERON_WAIT(10),
        .CMD_WAIT(4),
        .CLEAR_WAIT(8),
        .CNT_W(20)
    ) dut (
        .clk(clk),
        .reset(reset),
        .wr_en(wr_en),
        .wr_addr(wr_addr),
        .wr_data(wr_data),
        .refresh(refresh),
        .lcd_done(lcd_done),
        .lcd_start(lcd_start),
        .lcd_rs(lcd_rs),
        .lcd_data(lcd_data),
        .busy(busy),
        .init_done(init_done)
    );

    always #5 clk = ~clk;

    // Behavioural single-transfer controller
    int c_state;
    int c_cnt;
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_state  <= 0;
            c_cnt    <= 0;
            lcd_done <= 1'b1;
            lcd_en   <= 1'b0;
        end else begin
            case (c_state)
                0: if (lcd_start) begin
                    lcd_done <= 1'b0;
                    lcd_en   <= 1'b1;
                    c_cnt    <= 0;
                    c_state  <= 1;
                end
                1: if (c_cnt == CLK_WAIT - 1) begin
                    lcd_en  <= 1'b0;
                    c_cnt   <= 0;
                    c_state <= 2;
                end else begin
                    c_cnt <= c_cnt + 1;
                end
                default: if (c_cnt == CLK_WAIT - 1) begin
                    lcd_done <= 1'b1;
                    c_state  <= 0;
                end else begin
                    c_cnt <= c_cnt + 1;
                end
            endcase
        end
    end

    // Byte monitor
    always @(posedge lcd_en) begin
        mon_q.push_back({lcd_rs, lcd_data});
    end

    // Gap and idle-start monitor
    int   cyc = 0;
    int   done_cyc = 0;
    int   min_clr = 1000000;
    int   min_cmd = 1000000;
    int   idle_starts = 0;
    logic have_done = 1'b0;
    logic last_clr = 1'b0;
    logic done_p = 1'b0;
    logic start_p = 1'b0;
    always @(negedge clk) begin
        cyc++;
        if (!reset) begin
            have_done = 1'b0;
        end else begin
            if (lcd_done && !done_p && mon_q.size() > 0) begin
                have_done = 1'b1;
                done_cyc  = cyc;
                last_clr  = (mon_q[mon_q.size()-1] == 9'h001);
            end
            if (lcd_start && !start_p && have_done) begin
                if (last_clr) begin
                    if (cyc - done_cyc < min_clr) min_clr = cyc - done_cyc;
                end else begin
                    if (cyc - done_cyc < min_cmd) min_cmd = cyc - done_cyc;
                end
            end
            if (lcd_start && !busy) idle_starts++;
        end
        done_p  = lcd_done;
        start_p = lcd_start;
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic check_ge(input string name, input int act, input int lo);
        n_cmp++;
        if (act < lo || act >= 1000000) begin
            n_bad++;
            $display("FAIL %s: got %0d want >= %0d", name, act, lo);
        end
    endtask

    function automatic logic [8:0] exp_byte(input int s);
        case (s)
            0:  return 9'h038;
            1:  return 9'h00C;
            2:  return 9'h001;
            3:  return 9'h006;
            4:  return 9'h080;
            21: return 9'h0C0;
            default: begin
                if (s < 21) return {1'b1, shadow[s-5]};
                return {1'b1, shadow[s-6]};
            end
        endcase
    endfunction

    task automatic check_frame(input string name, input int first);
        logic [8:0] got;
        check({name, " count"}, mon_q.size(), 38 - first);
        for (int i = 0; i < 38 - first; i++) begin
            got = (i < mon_q.size()) ? mon_q[i] : 9'h1FF;
            check($sformatf("%s byte%0d", name, first + i), got,
                  exp_byte(first + i));
        end
    endtask

    task automatic wait_bytes(input string name, input int n,
                              output int lowc);
        int k = 0;
        lowc = 0;
        while (mon_q.size() < n && k < BUDGET) begin
            @(negedge clk);
            k++;
            if (!busy) lowc++;
        end
        if (mon_q.size() < n) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s timeout: got %0d bytes want %0d",
                     name, mon_q.size(), n);
        end
    endtask

    task automatic wait_settled(input string name);
        int quiet = 0;
        int k = 0;
        while (quiet < 40 && k < BUDGET) begin
            @(negedge clk);
            k++;
            quiet = busy ? 0 : quiet + 1;
        end
        check({name, " settled"}, (quiet >= 40), 1);
    endtask

    task automatic wait_init(input string name);
        int k = 0;
        while (!init_done && k < BUDGET) begin
            @(negedge clk);
            k++;
        end
        check({name, " init_done"}, init_done, 1);
        wait_settled(name);
    endtask

    task automatic no_start_window(input string name);
        int starts = 0;
        int lows = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (lcd_start) starts++;
            if (!busy) lows++;
        end
        check({name, " no start"}, starts, 0);
        check({name, " busy"}, lows, 0);
    endtask

    task automatic pulse_refresh();
        @(negedge clk);
        refresh = 1'b1;
        @(negedge clk);
        refresh = 1'b0;
    endtask

    task automatic write_fb(input logic [4:0] a, input logic [7:0] d);
        @(negedge clk);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        shadow[a] = d;
    endtask

    task automatic check_reset_outs(input string name);
        check({name, " lcd_start"}, lcd_start, 0);
        check({name, " lcd_rs"}, lcd_rs, 0);
        check({name, " lcd_data"}, lcd_data, 8'h00);
        check({name, " busy"}, busy, 1);
        check({name, " init_done"}, init_done, 0);
    endtask

    initial begin
        #1_000_000;
        $fatal(1, "FAIL watchdog: simulation time limit reached");
    end

    initial begin
        int lowc;
        reset   = 1'b0;
        wr_en   = 1'b0;
        wr_addr = 5'd0;
        wr_data = 8'h00;
        refresh = 1'b0;
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;

        vt[0] = '{1'b1, 5'd0,  8'h48, 1,  9'h148};
        vt[1] = '{1'b1, 5'd31, 8'h21, 33, 9'h121};
        vt[2] = '{1'b0, 5'd0,  8'h00, 0,  9'h080};
        vt[3] = '{1'b0, 5'd0,  8'h00, 17, 9'h0C0};
        vt[4] = '{1'b0, 5'd0,  8'h00, 2,  9'h120};
        vt[5] = '{1'b0, 5'd0,  8'h00, 32, 9'h120};

        repeat (3) @(negedge clk);
        check_reset_outs("reset");
        reset = 1'b1;
        no_start_window("pwr");
        wait_init("pwr");
        check_frame("pwr", 0);
        check("pwr busy", busy, 0);
        check_ge("clear gap", min_clr, 8);
        check_ge("cmd gap", min_cmd, 4);

        mon_q.delete();
        for (int i = 0; i < 6; i++) begin
            if (vt[i].wr) write_fb(vt[i].addr, vt[i].data);
        end
        pulse_refresh();
        check("ref busy", busy, 1);
        wait_bytes("ref", 34, lowc);
        check("ref busy low", lowc, 0);
        wait_settled("ref");
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ref vec%0d", i),
                  (vt[i].idx < mon_q.size()) ? mon_q[vt[i].idx] : 9'h1FF,
                  vt[i].exp);
        end
        check_frame("ref", 4);

        mon_q.delete();
        pulse_refresh();
        for (int i = 0; i < 3; i++) begin
            wait_bytes("coal", 3 + 5 * i, lowc);
            pulse_refresh();
        end
        wait_settled("coal");
        check("coal count", mon_q.size(), 68);
        check("coal 2nd hdr", (mon_q.size() > 34) ? mon_q[34] : 9'h1FF,
              9'h080);
        check("coal last", (mon_q.size() > 67) ? mon_q[67] : 9'h1FF,
              9'h121);

        mon_q.delete();
        pulse_refresh();
        wait_bytes("late", 7, lowc);
        write_fb(5'd20, 8'h41);
        wait_settled("late");
        check("late byte26", (mon_q.size() > 22) ? mon_q[22] : 9'h1FF,
              9'h141);
        check_frame("late", 4);

        mon_q.delete();
        pulse_refresh();
        wait_bytes("rst", 12, lowc);
        check("rst en high", lcd_en, 1);
        reset = 1'b0;
        #1;
        check_reset_outs("midrst");
        repeat (3) @(negedge clk);
        mon_q.delete();
        for (int i = 0; i < 32; i++) shadow[i] = 8'h20;
        reset = 1'b1;
        no_start_window("rerun");
        wait_init("rerun");
        check_frame("rerun", 0);

        check("idle starts", idle_starts, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/lcd_sequencer.md
Name: lcd_sequencer

Overview:
- Command/character sequencer that sits directly upstream of the single-transfer LCD controller and feeds it one byte at a time.
- Drives the controller's data, RS and start inputs; waits on its done flag between bytes.
- Power-up: runs the HD44780 init sequence, then writes a 32-character frame buffer (2 lines x 16) to the panel.
- After power-up: rewrites the whole frame on each refresh request. The host writes characters through a simple write port.

Parameters:
- POWERON_WAIT, 750000, idle cycles after reset before the first command (15 ms at 50 MHz).
- CMD_WAIT, 2000, gap cycles after each completed transfer (40 us).
- CLEAR_WAIT, 82000, gap cycles after the clear-display command (1.64 ms).
- CNT_W, 20, gap/power-on counter width. Must hold the largest wait value.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low reset
- wr_en  in  1  frame-buffer write strobe
- wr_addr  in  5  character index: 0-15 line 1, 16-31 line 2
- wr_data  in  8  character code
- refresh  in  1  request a full frame rewrite (level or pulse)
- lcd_done  in  1  done flag from the LCD controller
- lcd_start  out  1  start request to the LCD controller
- lcd_rs  out  1  RS to the controller: 0 = command, 1 = data
- lcd_data  out  8  byte to the controller
- busy  out  1  high while any sequence is in progress
- init_done  out  1  high once the init sequence has completed

Behaviour:
- Reset (reset low, asynchronous):
  - state=S_PWR, counter=0, step=0, refresh_pend=0.
  - Outputs: lcd_start=0, lcd_rs=0, lcd_data=8'h00, busy=1, init_done=0.
  - All 32 buffer entries = 8'h20 (space).
  - Reset mid-transfer aborts immediately; the full init sequence re-runs.
- Frame buffer:
  - 32x8 registers; synchronous write on wr_en.
  - Writable in any state. A step captures its character in S_LOAD, so a write landing before that cycle is displayed.
- Step table, index 0-37:
  - 0: 8'h38 (function set); 1: 8'h0C (display on); 2: 8'h01 (clear); 3: 8'h06 (entry mode). All with rs=0.
  - 4: 8'h80 (rs=0); 5-20: buf[0..15] (rs=1).
  - 21: 8'hC0 (rs=0); 22-37: buf[16..31] (rs=1).
- FSM states:
  - S_PWR: count to POWERON_WAIT-1, then step=0 -> S_LOAD.
  - S_LOAD: register lcd_data/lcd_rs from the step table -> S_WAITRDY.
  - S_WAITRDY: when lcd_done=1, set lcd_start=1 -> S_ACK.
  - S_ACK: hold lcd_start=1 until lcd_done=0, then lcd_start=0 -> S_XFER.
  - S_XFER: wait for lcd_done=1, counter=0 -> S_GAP.
  - S_GAP: count to W-1, where W=CLEAR_WAIT for step 2 and CMD_WAIT otherwise. Then:
    - if step=37: init_done=1 -> S_IDLE;
    - else step+1 -> S_LOAD.
  - S_IDLE: busy=0. If refresh or refresh_pend: clear refresh_pend, step=4, busy=1 -> S_LOAD.
- Output stability: lcd_data and lcd_rs stay stable from S_LOAD until the next S_LOAD, so the controller sees constant data while LCD_EN is high.
- Refresh handling:
  - refresh seen while busy sets refresh_pend; multiple requests coalesce into one.
  - refresh_pend is evaluated only in S_IDLE.
  - A refresh during power-up/init is served after init completes; the init itself already writes the frame.
- Idle: exactly one lcd_start assertion per step; lcd_start is never asserted while in S_IDLE.
- Controller stuck: no timeout. If lcd_done never rises, the FSM stalls in S_WAITRDY/S_XFER with busy=1.
- Counter: clears on every state entry; no wrap (terminal compare is ==).

Test Plan:
- Common bench setup:
  - POWERON_WAIT=10, CMD_WAIT=4, CLEAR_WAIT=8.
  - Real LCD controller instance, clk_wait=3, downstream of the sequencer.
  - A byte monitor samples lcd_data/lcd_rs on each rising edge of LCD_EN.
- Power-up: release reset, no writes -> no lcd_start for the first 10 cycles. Monitor sees 38 bytes in order: 38,0C,01,06,80 (rs=0), 16x20 (rs=1), C0 (rs=0), 16x20 (rs=1). Then init_done=1, busy=0.
- Clear gap: measure from lcd_done rising after byte 8'h01 to the next lcd_start -> at least 8 cycles; all other gaps at least 4 cycles.
- Refresh with content: write addr0=8'h48 and addr31=8'h21 while idle, pulse refresh -> monitor sees 80, 48, 15x20, C0, 15x20, 21. No init bytes; busy high throughout, low afterwards.
- Coalesced refresh: pulse refresh 3 times during an active refresh -> exactly one further 34-byte frame follows, then idle.
- Late write: write addr20=8'h41 while the sequencer is at step 10 -> 8'h41 appears as byte 26 (rs=1) of the same frame.
- Reset mid-operation: assert reset during step 15 while LCD_EN is high -> lcd_start=0, lcd_data=8'h00, busy=1, init_done=0 immediately. After release, the full 38-byte init repeats and the buffer reads back all 8'h20.
